// File: rtl/fp_divider_seq_if.sv
// fp_divider_seq_if -- operand/result handshake bundle for fp_divider_seq.
//   A, B          : IEEE-754 single-precision dividend and divisor
//   in_valid      : operands present (master -> divider)
//   in_ready      : divider idle and able to accept (divider -> master)
//   Result        : registered quotient, held while out_valid is high
//   out_valid     : Result and the exception flags are valid
//   out_ready     : consumer takes the result (master -> divider)
//   invalid, div_by_zero, overflow, underflow : exception flags
// master modport: the requester/consumer side; slave modport: the divider.
interface fp_divider_seq_if;
   logic [31:0] A;
   logic [31:0] B;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Result;
   logic        out_valid;
   logic        out_ready;
   logic        invalid;
   logic        div_by_zero;
   logic        overflow;
   logic        underflow;

   modport master (
      output A, B, in_valid, out_ready,
      input  in_ready, Result, out_valid, invalid, div_by_zero, overflow, underflow
   );

   modport slave (
      input  A, B, in_valid, out_ready,
      output in_ready, Result, out_valid, invalid, div_by_zero, overflow, underflow
   );
endinterface

// File: rtl/fp_divider_seq.sv
// fp_divider_seq -- sequential IEEE-754 single-precision divider.
// Restoring mantissa division, one quotient bit per clock, truncating result.
// Denormal operands are flushed to zero; special operands resolve in one cycle.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_divider_seq_if.slave (operand/result handshake and flags)
module fp_divider_seq (
   input  logic           clk,
   input  logic           rst_n,
   fp_divider_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

   state_t state, state_nxt;

   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic [24:0]        rem_q;
   logic [23:0]        div_q;
   logic [24:0]        quo_q;
   logic [4:0]         cnt_q;
   logic [31:0]        result_q;
   logic               inv_q, dbz_q, ovf_q, unf_q;

   logic               accept;

   // operand classification
   logic [7:0]  exp_a, exp_b;
   logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic        sign_ab;

   assign exp_a   = bus.A[30:23];
   assign exp_b   = bus.B[30:23];
   assign zero_a  = (exp_a == 8'h00);
   assign zero_b  = (exp_b == 8'h00);
   assign inf_a   = (exp_a == 8'hFF) && (bus.A[22:0] == '0);
   assign inf_b   = (exp_b == 8'hFF) && (bus.B[22:0] == '0);
   assign nan_a   = (exp_a == 8'hFF) && (bus.A[22:0] != '0);
   assign nan_b   = (exp_b == 8'hFF) && (bus.B[22:0] != '0);
   assign sign_ab = bus.A[31] ^ bus.B[31];

   assign bus.in_ready = (state == IDLE) && rst_n;
   assign accept       = bus.in_valid && bus.in_ready;

   // special-operand result, evaluated in priority order
   logic        spec_hit, spec_inv, spec_dbz;
   logic [31:0] spec_res;

   always_comb begin
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_dbz = 1'b0;
      spec_res = '0;
      if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
         spec_res = 32'h7FC0_0000;
         spec_inv = 1'b1;
      end else if (zero_b) begin
         spec_res = {sign_ab, 8'hFF, 23'h0};
         spec_dbz = 1'b1;
      end else if (inf_a) begin
         spec_res = {sign_ab, 8'hFF, 23'h0};
      end else if (zero_a || inf_b) begin
         spec_res = {sign_ab, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // biased exponent difference, signed so under/overflow remain visible
   logic signed [9:0] exp_in;
   assign exp_in = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;

   // one restoring-division step
   logic [24:0] div_ext, rem_diff;
   logic        q_bit;
   assign div_ext  = {1'b0, div_q};
   assign q_bit    = (rem_q >= div_ext);
   assign rem_diff = q_bit ? (rem_q - div_ext) : rem_q;

   // normalization: the quotient lies in (0.5, 2), so at most one left shift
   logic signed [9:0] exp_n;
   logic [22:0]       frac_n;
   logic              ovf_n, unf_n;
   logic [31:0]       norm_res;

   always_comb begin
      exp_n    = quo_q[24] ? exp_q : (exp_q - 10'sd1);
      frac_n   = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
      ovf_n    = (exp_n >= 10'sd255);
      unf_n    = (exp_n <= 10'sd0);
      norm_res = {sign_q, exp_n[7:0], frac_n};
      if (ovf_n) begin
         norm_res = {sign_q, 8'hFF, 23'h0};
      end else if (unf_n) begin
         norm_res = {sign_q, 31'h0};
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = spec_hit ? DONE : CALC;
         CALC: if (cnt_q == 5'd1) state_nxt = NORM;
         NORM: state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         inv_q    <= 1'b0;
         dbz_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign_q <= sign_ab;
                  inv_q  <= 1'b0;
                  dbz_q  <= 1'b0;
                  ovf_q  <= 1'b0;
                  unf_q  <= 1'b0;
                  if (spec_hit) begin
                     result_q <= spec_res;
                     inv_q    <= spec_inv;
                     dbz_q    <= spec_dbz;
                  end else begin
                     exp_q <= exp_in;
                     rem_q <= {2'b01, bus.A[22:0]};
                     div_q <= {1'b1, bus.B[22:0]};
                     quo_q <= '0;
                     cnt_q <= 5'd25;
                  end
               end
            end
            CALC: begin
               quo_q <= {quo_q[23:0], q_bit};
               rem_q <= rem_diff << 1;
               cnt_q <= cnt_q - 5'd1;
            end
            NORM: begin
               result_q <= norm_res;
               ovf_q    <= ovf_n;
               unf_q    <= unf_n && !ovf_n;
            end
            default: ;
         endcase
      end
   end

   assign bus.Result      = result_q;
   assign bus.out_valid   = (state == DONE);
   assign bus.invalid     = inv_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq -- self-checking bench for fp_divider_seq.
// Directed cases plus random operands checked against an arithmetic
// reference model (integer mantissa division, then normalize/truncate).
module tb_fp_divider_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   tests  = 0;
   int   failed = 0;

   fp_divider_seq_if bus();

   fp_divider_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags_now();
      return {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow};
   endfunction

   // reference: returns result, flags {invalid,dbz,ovf,unf}, and special-path marker
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] fl,
                                   output bit special);
      int     ea, eb, e;
      bit     s, za, zb, ia, ib, na, nb;
      longint ma, mb, q, frac;
      logic [22:0] f23;
      logic [7:0]  e8;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      fl = 4'b0000;
      special = 1'b1;
      if (na || nb || (za && zb) || (ia && ib)) begin
         r  = 32'h7FC0_0000;
         fl = 4'b1000;
      end else if (zb) begin
         r  = {s, 8'hFF, 23'h0};
         fl = 4'b0100;
      end else if (ia) begin
         r  = {s, 8'hFF, 23'h0};
      end else if (za || ib) begin
         r  = {s, 31'h0};
      end else begin
         special = 1'b0;
         ma = 64'(a[22:0]) + (64'd1 << 23);
         mb = 64'(b[22:0]) + (64'd1 << 23);
         q  = (ma * (64'd1 << 24)) / mb;   // quotient scaled by 2^24, truncated
         e  = ea - eb + 127;
         if (q >= (64'd1 << 24)) begin
            frac = q / 2 - (64'd1 << 23);
         end else begin
            frac = q - (64'd1 << 23);
            e    = e - 1;
         end
         f23 = 23'(frac);
         e8  = 8'(e);
         if (e >= 255) begin
            r  = {s, 8'hFF, 23'h0};
            fl = 4'b0010;
         end else if (e <= 0) begin
            r  = {s, 31'h0};
            fl = 4'b0001;
         end else begin
            r  = {s, e8, f23};
         end
      end
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] f;
      int          k;
      k = int'($urandom_range(0, 9));
      f = 23'($urandom);
      case (k)
         0: e = 8'h00;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = '0;
         end
         2: e = 8'h01;
         3: e = 8'hFE;
         default: e = 8'($urandom_range(60, 190));
      endcase
      return {1'($urandom), e, f};
   endfunction

   // one full transaction with latency, value, hold and release checks
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
      logic [31:0] er;
      logic [3:0]  ef;
      bit          sp;
      int          n;
      ref_div(a, b, er, ef, sp);
      @(negedge clk);
      chk({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.A         = a;
      bus.B         = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A        = $urandom;
      bus.B        = $urandom;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
         bus.A = $urandom;
         bus.B = $urandom;
      end
      bus.in_valid = 1'b0;
      chk({tag, " latency"}, 32'(n), sp ? 32'd0 : 32'd26);
      chk({tag, " result"}, bus.Result, er);
      chk({tag, " flags"}, 32'(flags_now()), 32'(ef));
      chk({tag, " busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, " hold_result"}, bus.Result, er);
         chk({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, " released_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " released_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int saw_valid;
      rst_n         = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset result", bus.Result, 32'h0);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset flags", 32'(flags_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset in_ready", 32'(bus.in_ready), 32'd1);

      run_op(32'h40C0_0000, 32'h4000_0000, "six_by_two", 0);
      chk("six_by_two const", bus.Result, 32'h4040_0000);
      run_op(32'h3F80_0000, 32'h4040_0000, "one_third", 10);
      chk("one_third const", bus.Result, 32'h3EAA_AAAA);
      run_op(32'h3F80_0000, 32'h0000_0000, "div_zero", 0);
      run_op(32'h0000_0000, 32'h0000_0000, "zero_zero", 0);
      run_op(32'h7F00_0000, 32'h0080_0000, "overflow", 0);
      run_op(32'h0080_0000, 32'h7F00_0000, "underflow", 0);
      run_op(32'hFF80_0000, 32'h7F80_0000, "inf_inf", 0);
      run_op(32'h7F80_0000, 32'hC000_0000, "inf_fin", 0);
      run_op(32'h4000_0000, 32'hFF80_0000, "fin_inf", 2);
      run_op(32'h7FC0_1234, 32'h3F80_0000, "nan_a", 0);
      run_op(32'h0000_1234, 32'hBF80_0000, "denorm_a", 0);

      for (int i = 0; i < 40; i++) begin
         run_op(rand_fp(), rand_fp(), "random", int'($urandom_range(0, 2)));
      end

      // abort during CALC
      @(negedge clk);
      bus.A        = 32'h40C0_0000;
      bus.B        = 32'h4000_0000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort result", bus.Result, 32'h0);
      chk("abort out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd0);
      chk("abort flags", 32'(flags_now()), 32'd0);
      saw_valid = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) saw_valid++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) saw_valid++;
      end
      chk("abort no_output", 32'(saw_valid), 32'd0);
      run_op(32'h40C0_0000, 32'h4000_0000, "recover", 0);
      chk("recover const", bus.Result, 32'h4040_0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
